// File: rtl/net_tx_sched.sv
// Packet-granular round-robin transmit scheduler with a token-bucket rate limiter.
// N_IN requesters share one 64-bit flit stream; grants only change at packet boundaries.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no grant held; search requesters from ptr+1 for a valid one
// S_BURST | requester grant_idx owns the output until its last flit fires
module net_tx_sched #(
    parameter int N_IN  = 2,
    parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [64*N_IN-1:0]    in_data,
    input  logic [8*N_IN-1:0]     in_keep,
    input  logic [N_IN-1:0]       in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_data,
    output logic [7:0]            out_keep,
    output logic                  out_last,
    input  logic [7:0]            rlimit_inc,
    input  logic [7:0]            rlimit_period,
    input  logic [7:0]            rlimit_size,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
);

    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    state_t             r_state;
    logic [7:0]         r_tokens;
    logic [7:0]         r_period_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_grant;

    logic               w_tick;
    logic               w_has_tok;
    logic               w_burst;
    logic               w_fire;
    logic [8:0]         w_tok_sum;
    logic [7:0]         w_tok_next;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;

    assign w_tick    = (r_period_cnt >= rlimit_period);
    assign w_has_tok = (r_tokens != 8'd0);
    assign w_burst   = (r_state == S_BURST);

    assign out_valid = w_burst && in_valid[r_grant] && w_has_tok;
    assign out_data  = in_data[64*int'(r_grant) +: 64];
    assign out_keep  = in_keep[8*int'(r_grant) +: 8];
    assign out_last  = in_last[r_grant];
    assign w_fire    = out_valid && out_ready;

    assign grant_idx = r_grant;
    assign busy      = w_burst;

    always_comb begin
        in_ready = '0;
        if (w_burst) begin
            in_ready[r_grant] = out_ready && w_has_tok;
        end
    end

    // Refill and consume are netted first, then clamped to the live bucket size.
    always_comb begin
        w_tok_sum  = {1'b0, r_tokens} + (w_tick ? {1'b0, rlimit_inc} : 9'd0) - {8'd0, w_fire};
        w_tok_next = (w_tok_sum > {1'b0, rlimit_size}) ? rlimit_size : w_tok_sum[7:0];
    end

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int k = 1; k <= N_IN; k++) begin
            idx = (int'(r_ptr) + k) % N_IN;
            if (!w_found && in_valid[idx]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tokens     <= 8'd0;
            r_period_cnt <= 8'd0;
            r_ptr        <= IDX_W'(N_IN - 1);
            r_grant      <= '0;
        end else begin
            r_period_cnt <= w_tick ? 8'd0 : r_period_cnt + 8'd1;
            r_tokens     <= w_tok_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_sel;
                        r_state <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_fire && out_last) begin
                        r_ptr   <= r_grant;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_net_tx_sched.sv
// Bench for net_tx_sched: table of rate-limit scenarios plus arbitration,
// backpressure and mid-packet reset sequences, with a per-requester flit scoreboard.
module tb_net_tx_sched;
    localparam int N = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [64*N-1:0]   in_data;
    logic [8*N-1:0]    in_keep;
    logic [N-1:0]      in_last;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [7:0]        out_keep;
    logic              out_last;
    logic [7:0]        rlimit_inc;
    logic [7:0]        rlimit_period;
    logic [7:0]        rlimit_size;
    logic              grant_idx;
    logic              busy;

    net_tx_sched #(.N_IN(N)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .rlimit_inc(rlimit_inc), .rlimit_period(rlimit_period), .rlimit_size(rlimit_size),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } flit_t;

    typedef struct {
        int inc;
        int period;
        int size;
        int idle;
        int len;
        int exp_last;
    } vec_t;

    flit_t src_q[N][$];
    flit_t exp_q[N][$];
    int    pkt_order[$];
    int    fire_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc;
    int    nfires;
    int    last_fire;

    logic          s_ovalid;
    logic          s_busy;
    logic [N-1:0]  s_iready;
    logic [63:0]   s_data;
    logic [7:0]    s_keep;
    logic          s_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                in_valid[i]        = 1'b1;
                in_data[64*i +: 64] = src_q[i][0].data;
                in_keep[8*i +: 8]   = src_q[i][0].keep;
                in_last[i]         = src_q[i][0].last;
            end else begin
                in_valid[i]        = 1'b0;
                in_data[64*i +: 64] = '0;
                in_keep[8*i +: 8]   = '0;
                in_last[i]         = 1'b0;
            end
        end
    endtask

    task automatic load_packet(input int r, input int len, input int tag);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.data = {$urandom(), 8'(tag), 8'(r), 16'(k)};
            f.keep = 8'($urandom_range(1, 255));
            f.last = (k == len - 1);
            src_q[r].push_back(f);
            exp_q[r].push_back(f);
        end
    endtask

    // One clock: sample and score at negedge, then advance sources just after posedge.
    task automatic cycle();
        logic         fire;
        logic [N-1:0] acc;
        logic [N-1:0] exp_acc;
        flit_t        e;
        @(negedge clock);
        cyc++;
        s_ovalid = out_valid;
        s_busy   = busy;
        s_iready = in_ready;
        s_data   = out_data;
        s_keep   = out_keep;
        s_grant  = grant_idx;
        fire     = out_valid && out_ready;
        acc      = in_valid & in_ready;
        exp_acc  = '0;
        if (fire) exp_acc[grant_idx] = 1'b1;
        check("accept_onehot", 64'(acc), 64'(exp_acc));
        if (!busy) check("idle_quiet", 64'({out_valid, in_ready}), 64'(0));
        if (fire) begin
            nfires++;
            last_fire = cyc;
            fire_cyc.push_back(cyc);
            if (exp_q[grant_idx].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: fire from requester %0d with nothing expected", grant_idx);
            end else begin
                e = exp_q[grant_idx].pop_front();
                check("out_data", out_data, e.data);
                check("out_keep", 64'(out_keep), 64'(e.keep));
                check("out_last", 64'(out_last), 64'(e.last));
                if (e.last) pkt_order.push_back(int'(grant_idx));
            end
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_inputs();
    endtask

    task automatic do_reset(input int inc, input int period, input int size);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        pkt_order.delete();
        fire_cyc.delete();
        nfires        = 0;
        last_fire     = -1;
        out_ready     = 1'b1;
        rlimit_inc    = 8'(inc);
        rlimit_period = 8'(period);
        rlimit_size   = 8'(size);
        drive_inputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = -1;
    endtask

    task automatic check_order(input string name, input int o0, input int o1, input int o2,
                               input int o3, input int n);
        int exp_o[4];
        exp_o = '{o0, o1, o2, o3};
        check_i({name, "_count"}, pkt_order.size(), n);
        for (int i = 0; i < n && i < pkt_order.size(); i++) begin
            check_i(name, pkt_order[i], exp_o[i]);
        end
    endtask

    initial begin
        vec_t  vecs[6];
        flit_t h;
        vecs[0] = '{1, 0, 8, 0, 4, 4};
        vecs[1] = '{1, 3, 1, 0, 10, 40};
        vecs[2] = '{1, 1, 4, 20, 12, 16};
        vecs[3] = '{8, 0, 8, 0, 5, 5};
        vecs[4] = '{2, 2, 3, 0, 6, 10};
        vecs[5] = '{3, 0, 0, 0, 3, -1};

        in_valid = '0;
        in_data  = '0;
        in_keep  = '0;
        in_last  = '0;
        out_ready = 1'b1;
        rlimit_inc = 8'd0;
        rlimit_period = 8'd0;
        rlimit_size = 8'd0;

        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant", 64'(grant_idx), 64'(0));

        // Single-requester rate-limit scenarios; exp_last is the cycle of the last fire
        // counted from the cycle in which in_valid first appears (-1 = never fires).
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].inc, vecs[v].period, vecs[v].size);
            for (int k = 0; k < vecs[v].idle; k++) cycle();
            cyc = -1;
            load_packet(0, vecs[v].len, v);
            drive_inputs();
            for (int k = 0; k < 80; k++) begin
                cycle();
                if (nfires == vecs[v].len) break;
            end
            check_i($sformatf("vec%0d_last_fire", v), last_fire, vecs[v].exp_last);
            check_i($sformatf("vec%0d_nfires", v), nfires, (vecs[v].exp_last < 0) ? 0 : vecs[v].len);
            cycle();
            check($sformatf("vec%0d_busy_after", v), 64'(s_busy), 64'(vecs[v].exp_last < 0));
            check($sformatf("vec%0d_ovalid_after", v), 64'(s_ovalid), 64'(0));
        end

        // Two requesters, continuous 3-flit packets, no rate limit.
        do_reset(8, 0, 8);
        load_packet(0, 3, 10);
        load_packet(0, 3, 11);
        load_packet(1, 3, 20);
        load_packet(1, 3, 21);
        drive_inputs();
        for (int k = 0; k < 60 && nfires < 12; k++) cycle();
        check_order("rr_order", 0, 1, 0, 1, 4);
        check_i("rr_last_fire", last_fire, 15);

        // Backpressure for 5 cycles mid-packet with the other requester waiting.
        do_reset(3, 9, 3);
        for (int k = 0; k < 10; k++) cycle();
        cyc = -1;
        load_packet(0, 6, 50);
        load_packet(1, 2, 51);
        drive_inputs();
        for (int k = 0; k < 3; k++) cycle();
        out_ready = 1'b0;
        h = exp_q[0][0];
        for (int s = 0; s < 5; s++) begin
            cycle();
            check("bp_out_valid", 64'(s_ovalid), 64'(1));
            check("bp_out_data", s_data, h.data);
            check("bp_out_keep", 64'(s_keep), 64'(h.keep));
            check("bp_grant", 64'(s_grant), 64'(0));
            check("bp_in_ready", 64'(s_iready), 64'(0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 60 && nfires < 8; k++) cycle();
        check_i("bp_fire_count", fire_cyc.size(), 8);
        if (fire_cyc.size() >= 3) check_i("bp_resume_cycle", fire_cyc[2], 8);
        check_i("bp_last_fire", last_fire, 21);
        check_order("bp_order", 0, 1, 0, 0, 2);

        // Asynchronous reset between edges while flit 2 of 6 is on the output.
        do_reset(8, 0, 8);
        load_packet(0, 6, 60);
        load_packet(1, 2, 61);
        drive_inputs();
        for (int k = 0; k < 3; k++) cycle();
        #2;
        check("ar_pre_valid", 64'(out_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'(0));
        check("ar_in_ready", 64'(in_ready), 64'(0));
        check("ar_busy", 64'(busy), 64'(0));
        check("ar_tokens", 64'(dut.r_tokens), 64'(0));
        do_reset(8, 0, 8);
        load_packet(0, 2, 62);
        load_packet(1, 2, 63);
        drive_inputs();
        for (int k = 0; k < 40 && nfires < 4; k++) cycle();
        check_order("ar_order", 0, 1, 0, 0, 2);
        check_i("ar_last_fire", last_fire, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
